// File: rtl/sig_buffer_pkg.sv
// rtl/sig_buffer_pkg.sv - shared constants, FSM encoding and sample word type for sig_buffer
package sig_buffer_pkg;

   localparam int WIDTH = 4;
   localparam int TRATE = 5;
   localparam int TBITS = 3;
   localparam int COUNT = 15;
   localparam int CBITS = 4;
   localparam int BBITS = 1;
   localparam int ABITS = BBITS + CBITS;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_REPLAY = 1'b1
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] i;
      logic [WIDTH-1:0] q;
   } sample_t;

endpackage

// File: rtl/sig_buffer_if.sv
// rtl/sig_buffer_if.sv - sample input and replay output bundle for sig_buffer
interface sig_buffer_if
   import sig_buffer_pkg::*;
   ;

   logic             valid_i;
   logic [WIDTH-1:0] idata_i;
   logic [WIDTH-1:0] qdata_i;
   logic             valid_o;
   logic             first_o;
   logic             last_o;
   logic [TBITS-1:0] taddr_o;
   logic [WIDTH-1:0] idata_o;
   logic [WIDTH-1:0] qdata_o;

   modport master (
      output valid_i, idata_i, qdata_i,
      input  valid_o, first_o, last_o, taddr_o, idata_o, qdata_o
   );

   modport slave (
      input  valid_i, idata_i, qdata_i,
      output valid_o, first_o, last_o, taddr_o, idata_o, qdata_o
   );

endinterface

// File: rtl/sig_buffer_sram.sv
// rtl/sig_buffer_sram.sv - simple dual-port memory, one write port and one synchronous read port
module sig_buffer_sram
   import sig_buffer_pkg::*;
#(
   parameter int DW = 2 * WIDTH,
   parameter int AW = ABITS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Only the read register is reset, so replay data reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sig_buffer.sv
// rtl/sig_buffer.sv - banked sample capture with TRATE-fold replay per completed bank
module sig_buffer
   import sig_buffer_pkg::*;
(
   input  logic         vis_clk,
   input  logic         reset_n,
   sig_buffer_if.slave  bus
);

   logic [CBITS-1:0] windex;
   logic [BBITS-1:0] wbank;
   logic             pending;
   logic [BBITS-1:0] pend_bank;

   state_t           state;
   logic [BBITS-1:0] rbank;
   logic [CBITS-1:0] rindex;
   logic [TBITS-1:0] taddr;

   logic             valid_q;
   logic             first_q;
   logic             last_q;
   logic [TBITS-1:0] taddr_q;

   sample_t          wword;
   sample_t          rword;
   logic             wr_last;
   logic             rd_end;
   logic             take;

   assign wword   = {bus.idata_i, bus.qdata_i};
   assign wr_last = bus.valid_i && (windex == CBITS'(COUNT - 1));
   assign rd_end  = (state == ST_REPLAY) && (taddr == TBITS'(TRATE - 1))
                    && (rindex == CBITS'(COUNT - 1));
   assign take    = pending && ((state == ST_IDLE) || rd_end);

   sig_buffer_sram #(
      .DW (2 * WIDTH),
      .AW (ABITS)
   ) u_sram (
      .clk   (vis_clk),
      .rst_n (reset_n),
      .we    (bus.valid_i),
      .waddr ({wbank, windex}),
      .wdata (wword),
      .re    (state == ST_REPLAY),
      .raddr ({rbank, rindex}),
      .rdata (rword)
   );

   // A completion landing on the same edge the FSM consumes the old one keeps pending set.
   always_ff @(posedge vis_clk or negedge reset_n) begin
      if (!reset_n) begin
         windex    <= '0;
         wbank     <= '0;
         pending   <= 1'b0;
         pend_bank <= '0;
      end else begin
         if (bus.valid_i) begin
            if (wr_last) begin
               windex <= '0;
               wbank  <= wbank + 1'b1;
            end else begin
               windex <= windex + 1'b1;
            end
         end
         if (wr_last) begin
            pending   <= 1'b1;
            pend_bank <= wbank;
         end else if (take) begin
            pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge vis_clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         rbank   <= '0;
         rindex  <= '0;
         taddr   <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         taddr_q <= '0;
      end else begin
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         taddr_q <= '0;
         case (state)
            ST_IDLE: begin
               if (take) begin
                  state  <= ST_REPLAY;
                  rbank  <= pend_bank;
                  rindex <= '0;
                  taddr  <= '0;
               end
            end
            ST_REPLAY: begin
               // Flags describe the word whose read is issued this cycle.
               valid_q <= 1'b1;
               first_q <= (rindex == '0);
               last_q  <= (rindex == CBITS'(COUNT - 1));
               taddr_q <= taddr;
               if (rindex == CBITS'(COUNT - 1)) begin
                  rindex <= '0;
                  if (taddr == TBITS'(TRATE - 1)) begin
                     taddr <= '0;
                     if (take) begin
                        rbank <= pend_bank;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     taddr <= taddr + 1'b1;
                  end
               end else begin
                  rindex <= rindex + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.valid_o = valid_q;
   assign bus.first_o = first_q;
   assign bus.last_o  = last_q;
   assign bus.taddr_o = taddr_q;
   assign bus.idata_o = rword.i;
   assign bus.qdata_o = rword.q;

endmodule

// File: tb/tb_sig_buffer.sv
// tb/tb_sig_buffer.sv - self-checking bench for sig_buffer with table-driven sample vectors
module tb_sig_buffer;
   import sig_buffer_pkg::*;

   typedef struct {
      logic [3:0] i;
      logic [3:0] q;
   } vec_t;

   typedef struct {
      int         cyc;
      logic       first;
      logic       last;
      logic [2:0] taddr;
      logic [3:0] i;
      logic [3:0] q;
   } obs_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   int     cyc = 0;
   int     errors = 0;
   int     checks = 0;
   int     wlast;
   vec_t   tbl [30];
   int     gaps [15];
   obs_t   log_q [$];

   sig_buffer_if bus ();

   sig_buffer dut (
      .vis_clk (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.valid_o === 1'b1) begin
         log_q.push_back('{cyc, bus.first_o, bus.last_o, bus.taddr_o, bus.idata_o, bus.qdata_o});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.valid_i = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      log_q.delete();
   endtask

   task automatic write_one(input vec_t v, input int gap);
      bus.valid_i = 1'b1;
      bus.idata_i = v.i;
      bus.qdata_i = v.q;
      tick();
      wlast = cyc;
      bus.valid_i = 1'b0;
      repeat (gap - 1) tick();
   endtask

   task automatic check_replay(input string name, input int tb_base, input int log_base,
                               input int start);
      obs_t        r;
      logic [31:0] act;
      logic [31:0] exp;
      for (int p = 0; p < 5; p++) begin
         for (int k = 0; k < 15; k++) begin
            int n;
            n = p * 15 + k;
            if (log_base + n < log_q.size()) r = log_q[log_base + n];
            else r = '{0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0};
            act = {3'd0, r.cyc[15:0], r.first, r.last, r.taddr, r.i, r.q};
            exp = {3'd0, 16'(start + n), (k == 0), (k == 14), 3'(p),
                   tbl[tb_base + k].i, tbl[tb_base + k].q};
            chk($sformatf("%s_p%0d_k%0d", name, p, k), act, exp);
         end
      end
   endtask

   initial begin
      tbl = '{'{4'h1, 4'hE}, '{4'h7, 4'h2}, '{4'hA, 4'h5}, '{4'h3, 4'hC}, '{4'hF, 4'h0},
              '{4'h6, 4'h9}, '{4'h0, 4'hB}, '{4'hD, 4'h4}, '{4'h8, 4'h8}, '{4'h2, 4'h7},
              '{4'hC, 4'h1}, '{4'h5, 4'hA}, '{4'hE, 4'h3}, '{4'h9, 4'hD}, '{4'h4, 4'h6},
              '{4'hB, 4'hF}, '{4'h2, 4'h2}, '{4'h9, 4'h0}, '{4'h5, 4'h7}, '{4'h0, 4'h3},
              '{4'hF, 4'hA}, '{4'h6, 4'hC}, '{4'h1, 4'h1}, '{4'hE, 4'h8}, '{4'h8, 4'h5},
              '{4'h3, 4'hE}, '{4'hD, 4'h9}, '{4'h7, 4'h4}, '{4'hA, 4'hB}, '{4'h4, 4'hD}};
      gaps = '{5, 7, 12, 9, 6, 11, 8, 10, 5, 12, 7, 6, 9, 11, 8};
      bus.valid_i = 1'b0;
      bus.idata_i = '0;
      bus.qdata_i = '0;

      // Reset held with valid_i toggling
      for (int c = 0; c < 10; c++) begin
         bus.valid_i = c[0];
         bus.idata_i = 4'(c);
         bus.qdata_i = 4'(~c);
         tick();
         chk("rst_outputs", {16'd0, bus.valid_o, bus.first_o, bus.last_o, bus.taddr_o,
                             bus.idata_o, bus.qdata_o}, 32'd0);
      end
      bus.valid_i = 1'b0;
      rst_n = 1'b1;
      repeat (30) tick();
      chk("rst_no_valid", log_q.size(), 0);

      // One bank at the contract rate
      do_reset();
      for (int k = 0; k < 15; k++) write_one(tbl[k], 5);
      repeat (90) tick();
      chk("one_bank_count", log_q.size(), 75);
      check_replay("one_bank", 0, 0, wlast + 2);

      // Two banks back to back
      do_reset();
      begin
         int w0;
         for (int k = 0; k < 15; k++) write_one(tbl[k], 5);
         w0 = wlast;
         for (int k = 15; k < 30; k++) write_one(tbl[k], 5);
         chk("two_bank_spacing", wlast - w0, 75);
         repeat (90) tick();
         chk("two_bank_count", log_q.size(), 150);
         check_replay("bank0", 0, 0, w0 + 2);
         check_replay("bank1", 15, 75, wlast + 2);
      end

      // Partial bank never replays
      do_reset();
      for (int k = 0; k < 14; k++) write_one(tbl[k], 5);
      repeat (120) tick();
      chk("partial_no_valid", log_q.size(), 0);

      // Reset during replay
      do_reset();
      for (int k = 15; k < 30; k++) write_one(tbl[k], 5);
      while (cyc < wlast + 22) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {16'd0, bus.valid_o, bus.first_o, bus.last_o, bus.taddr_o,
                             bus.idata_o, bus.qdata_o}, 32'd0);
      chk("midrst_pre_count", log_q.size(), 20);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      log_q.delete();
      for (int k = 0; k < 15; k++) write_one(tbl[k], 5);
      repeat (90) tick();
      chk("midrst_count", log_q.size(), 75);
      check_replay("midrst", 0, 0, wlast + 2);

      // Irregular input gaps
      do_reset();
      for (int k = 0; k < 15; k++) write_one(tbl[15 + k], gaps[k]);
      repeat (90) tick();
      chk("irregular_count", log_q.size(), 75);
      check_replay("irregular", 15, 0, wlast + 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
